// File: rtl/block_map_unit.sv
// block_map_unit: COLS x ROWS tile-id map with a registered renderer read port and question-block hits.
// Build option BLOCK_BUMP_EN adds the animated bump FSM; without it a hit rewrites the tile immediately.
module block_map_unit #(
   parameter int COLS      = 20,
   parameter int ROWS      = 15,
   parameter int ID_W      = 4,
   parameter int QBLOCK_ID = 3,
   parameter int USED_ID   = 4,
   parameter int BUMP_H    = 4
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     change_id,
   input  logic [$clog2(COLS)-1:0]  wr_col,
   input  logic [$clog2(ROWS)-1:0]  wr_row,
   input  logic [ID_W-1:0]          new_block_id,
   input  logic [$clog2(COLS)-1:0]  rd_col,
   input  logic [$clog2(ROWS)-1:0]  rd_row,
   output logic [ID_W-1:0]          rd_block_id,
   input  logic                     frame_tick,
   input  logic                     hit,
   input  logic [$clog2(COLS)-1:0]  hit_col,
   input  logic [$clog2(ROWS)-1:0]  hit_row,
   output logic                     hit_busy,
   output logic [$clog2(COLS)-1:0]  bump_col,
   output logic [$clog2(ROWS)-1:0]  bump_row,
   output logic [3:0]               bump_offset
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam logic [CW-1:0]   COL_MAX = CW'(COLS - 1);
   localparam logic [RW-1:0]   ROW_MAX = RW'(ROWS - 1);
   localparam logic [ID_W-1:0] QID     = ID_W'(QBLOCK_ID);
   localparam logic [ID_W-1:0] UID     = ID_W'(USED_ID);

   function automatic logic in_map(input logic [CW-1:0] c, input logic [RW-1:0] r);
      return (c <= COL_MAX) && (r <= ROW_MAX);
   endfunction

   logic [ID_W-1:0] map [ROWS][COLS];

   logic            wr_ok;
   logic            rd_ok;
   logic            hit_in_map;
   logic [ID_W-1:0] hit_id;
   logic            hit_ok;
   logic            wb_en;
   logic [CW-1:0]   wb_col;
   logic [RW-1:0]   wb_row;

   assign wr_ok      = change_id && in_map(wr_col, wr_row);
   assign rd_ok      = in_map(rd_col, rd_row);
   assign hit_in_map = in_map(hit_col, hit_row);
   // Hit qualification looks at the stored id before any same-edge write lands.
   assign hit_id     = hit_in_map ? map[hit_row][hit_col] : '0;

`ifdef BLOCK_BUMP_EN
   typedef enum logic [1:0] {IDLE, UP, DOWN} bump_state_t;

   localparam logic [3:0] BUMP_TOP = 4'(BUMP_H);

   bump_state_t   state_q, state_d;
   logic [3:0]    offset_q, offset_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   assign hit_ok = hit && hit_in_map && (hit_id == QID) && (state_q == IDLE);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         offset_q <= '0;
         col_q    <= '0;
         row_q    <= '0;
      end else begin
         // NOTE: sequential state always uses <= so every flop samples pre-edge values.
         state_q  <= state_d;
         offset_q <= offset_d;
         col_q    <= col_d;
         row_q    <= row_d;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first, so no path through the case infers a latch.
      state_d  = state_q;
      offset_d = offset_q;
      col_d    = col_q;
      row_d    = row_q;
      wb_en    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (hit_ok) begin
               col_d    = hit_col;
               row_d    = hit_row;
               offset_d = '0;
               state_d  = UP;
            end
         end
         UP: begin
            if (frame_tick) begin
               offset_d = offset_q + 4'd1;
               if (offset_d == BUMP_TOP) state_d = DOWN;
            end
         end
         DOWN: begin
            if (frame_tick) begin
               offset_d = offset_q - 4'd1;
               if (offset_d == 4'd0) begin
                  state_d = IDLE;
                  wb_en   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wb_col      = col_q;
   assign wb_row      = row_q;
   assign hit_busy    = (state_q != IDLE);
   assign bump_col    = col_q;
   assign bump_row    = row_q;
   assign bump_offset = offset_q;
`else
   logic unused_bump_cfg;

   assign hit_ok          = hit && hit_in_map && (hit_id == QID);
   assign wb_en           = hit_ok;
   assign wb_col          = hit_col;
   assign wb_row          = hit_row;
   assign hit_busy        = 1'b0;
   assign bump_col        = '0;
   assign bump_row        = '0;
   assign bump_offset     = '0;
   assign unused_bump_cfg = &{1'b0, frame_tick, 4'(BUMP_H)};
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         // NOTE: the map is a flop array rather than a RAM because reset must clear every entry in one edge.
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               map[RW'(r)][CW'(c)] <= '0;
            end
         end
         rd_block_id <= '0;
      end else begin
         rd_block_id <= rd_ok ? map[rd_row][rd_col] : '0;
         if (wb_en) map[wb_row][wb_col] <= UID;
         // Issued after the writeback so a colliding change_id is the value that sticks.
         if (wr_ok) map[wr_row][wr_col] <= new_block_id;
      end
   end

endmodule
